// File: rtl/cal_pkg.sv
// Calendar constants and helpers shared by the day-of-year counter.
// Month lengths and small binary-to-BCD conversion for 28..31.
package cal_pkg;

  localparam int unsigned DAYS_NORMAL = 365;
  localparam int unsigned DAYS_LEAP   = 366;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic [4:0] month_len(
    input logic [3:0] m,
    input logic       leap
  );
    logic [4:0] n;
    case (m)
      4'd2:    n = leap ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   n = 5'd30;
      default: n = 5'd31;
    endcase
    return n;
  endfunction

  // Month lengths are always 28..31, so two subtractions suffice.
  function automatic logic [7:0] len_bcd(input logic [4:0] n);
    bcd_digit_t tens;
    bcd_digit_t ones;
    if (n >= 5'd30) begin
      tens = 4'd3;
      ones = 4'(n - 5'd30);
    end else begin
      tens = 4'd2;
      ones = 4'(n - 5'd20);
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd3_updown.sv
// Multi-digit BCD up/down counter with synchronous load.
// Load beats inc/dec; inc beats dec.
module bcd3_updown
  import cal_pkg::*;
#(
  parameter int unsigned          NDIG    = 3,
  parameter logic [4*NDIG-1:0]    RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              inc,
  input  logic              dec,
  output logic [4*NDIG-1:0] q
);

  logic [4*NDIG-1:0] cnt_q;
  logic [4*NDIG-1:0] cnt_d;
  logic              cy;
  bcd_digit_t        dig;

  always_comb begin
    cnt_d = cnt_q;
    cy    = 1'b1;
    dig   = '0;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      for (int i = 0; i < NDIG; i++) begin
        dig = cnt_q[4*i +: 4];
        if (cy) begin
          if (dig == 4'd9) begin
            cnt_d[4*i +: 4] = 4'd0;
          end else begin
            cnt_d[4*i +: 4] = dig + 4'd1;
            cy = 1'b0;
          end
        end
      end
    end else if (dec) begin
      for (int i = 0; i < NDIG; i++) begin
        dig = cnt_q[4*i +: 4];
        if (cy) begin
          if (dig == 4'd0) begin
            cnt_d[4*i +: 4] = 4'd9;
          end else begin
            cnt_d[4*i +: 4] = dig - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/day_of_year_calendar.sv
// Day-of-year calendar: prescaled tick, run/step, up/down, leap mode.
// Binary state drives decisions; BCD counters track it incrementally.
module day_of_year_calendar
  import cal_pkg::*;
#(
  parameter int unsigned DIV0 = 10_000_000,
  parameter int unsigned DIV1 = 2_500_000,
  parameter int unsigned DIV2 = 500_000,
  parameter int unsigned DIV3 = 50_000,
  parameter int unsigned PW   = 24
) (
  input  logic        ADC_CLK_10,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        dir,
  input  logic        leap,
  input  logic [1:0]  speed,
  output logic [11:0] doy_bcd,
  output logic [3:0]  month,
  output logic [7:0]  dom_bcd,
  output logic        tick,
  output logic        wrap
);

  logic [PW-1:0] cnt_q, cnt_d, div_m1;
  logic          tick_q, tick_d;
  logic          adv;

  always_comb begin
    unique case (speed)
      2'd0:    div_m1 = PW'(DIV0 - 1);
      2'd1:    div_m1 = PW'(DIV1 - 1);
      2'd2:    div_m1 = PW'(DIV2 - 1);
      default: div_m1 = PW'(DIV3 - 1);
    endcase
  end

  // >= so that switching to a shorter divisor reloads at once.
  always_comb begin
    tick_d = (cnt_q >= div_m1);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign adv = (run & tick_q) | (~run & step);

  logic [8:0]  doy_q, doy_d, ylen;
  logic [3:0]  month_q, month_d, prev_m;
  logic [4:0]  dom_q, dom_d, cur_len, prev_len;
  logic        wrap_q, wrap_d;
  logic        doy_ld, doy_inc, doy_dec;
  logic [11:0] doy_ldv, ylen_bcd;
  logic        dom_ld, dom_inc, dom_dec;
  logic [7:0]  dom_ldv;

  always_comb begin
    ylen     = leap ? 9'(DAYS_LEAP) : 9'(DAYS_NORMAL);
    ylen_bcd = leap ? 12'h366 : 12'h365;
    cur_len  = month_len(month_q, leap);
    prev_m   = month_q - 4'd1;
    prev_len = month_len(prev_m, leap);
  end

  always_comb begin
    doy_d   = doy_q;
    month_d = month_q;
    dom_d   = dom_q;
    wrap_d  = 1'b0;
    doy_ld  = 1'b0;
    doy_ldv = '0;
    doy_inc = 1'b0;
    doy_dec = 1'b0;
    dom_ld  = 1'b0;
    dom_ldv = '0;
    dom_inc = 1'b0;
    dom_dec = 1'b0;
    if (adv && !dir) begin
      if (doy_q >= ylen) begin
        doy_d   = 9'd1;
        month_d = 4'd1;
        dom_d   = 5'd1;
        wrap_d  = 1'b1;
        doy_ld  = 1'b1;
        doy_ldv = 12'h001;
        dom_ld  = 1'b1;
        dom_ldv = 8'h01;
      end else if (dom_q >= cur_len) begin
        doy_d   = doy_q + 9'd1;
        month_d = month_q + 4'd1;
        dom_d   = 5'd1;
        doy_inc = 1'b1;
        dom_ld  = 1'b1;
        dom_ldv = 8'h01;
      end else begin
        doy_d   = doy_q + 9'd1;
        dom_d   = dom_q + 5'd1;
        doy_inc = 1'b1;
        dom_inc = 1'b1;
      end
    end else if (adv && dir) begin
      if (doy_q <= 9'd1) begin
        doy_d   = ylen;
        month_d = 4'd12;
        dom_d   = 5'd31;
        wrap_d  = 1'b1;
        doy_ld  = 1'b1;
        doy_ldv = ylen_bcd;
        dom_ld  = 1'b1;
        dom_ldv = 8'h31;
      end else if (dom_q <= 5'd1) begin
        doy_d   = doy_q - 9'd1;
        month_d = prev_m;
        dom_d   = prev_len;
        doy_dec = 1'b1;
        dom_ld  = 1'b1;
        dom_ldv = len_bcd(prev_len);
      end else begin
        doy_d   = doy_q - 9'd1;
        dom_d   = dom_q - 5'd1;
        doy_dec = 1'b1;
        dom_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      doy_q   <= 9'd1;
      month_q <= 4'd1;
      dom_q   <= 5'd1;
      wrap_q  <= 1'b0;
    end else begin
      doy_q   <= doy_d;
      month_q <= month_d;
      dom_q   <= dom_d;
      wrap_q  <= wrap_d;
    end
  end

  bcd3_updown #(
    .NDIG    (3),
    .RST_VAL (12'h001)
  ) u_doy (
    .clk      (ADC_CLK_10),
    .rst      (reset),
    .load     (doy_ld),
    .load_val (doy_ldv),
    .inc      (doy_inc),
    .dec      (doy_dec),
    .q        (doy_bcd)
  );

  bcd3_updown #(
    .NDIG    (2),
    .RST_VAL (8'h01)
  ) u_dom (
    .clk      (ADC_CLK_10),
    .rst      (reset),
    .load     (dom_ld),
    .load_val (dom_ldv),
    .inc      (dom_inc),
    .dec      (dom_dec),
    .q        (dom_bcd)
  );

  assign month = month_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_day_of_year_calendar.sv
// Bench for day_of_year_calendar: cycle-level calendar model,
// directed boundary steps and randomized run/step traffic.
module tb_day_of_year_calendar;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic        leap = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic [11:0] doy_bcd;
  logic [3:0]  month;
  logic [7:0]  dom_bcd;
  logic        tick;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  int m_doy, m_mon, m_dom, m_cnt;
  bit m_tick, m_wrap;
  int divs[4] = '{6, 4, 3, 2};

  always #5 clk = ~clk;

  day_of_year_calendar #(
    .DIV0 (6),
    .DIV1 (4),
    .DIV2 (3),
    .DIV3 (2),
    .PW   (24)
  ) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .dir        (dir),
    .leap       (leap),
    .speed      (speed),
    .doy_bcd    (doy_bcd),
    .month      (month),
    .dom_bcd    (dom_bcd),
    .tick       (tick),
    .wrap       (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mlen(input int m, input bit lp);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && lp) return 29;
    return t[m-1];
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic advance(input bit d, input bit lp, output bit w);
    int yl;
    yl = lp ? 366 : 365;
    w = 0;
    if (!d) begin
      if (m_doy >= yl) begin
        m_doy = 1; m_mon = 1; m_dom = 1; w = 1;
      end else begin
        m_doy++;
        m_dom++;
        if (m_dom > mlen(m_mon, lp)) begin
          m_dom = 1;
          m_mon++;
        end
      end
    end else begin
      if (m_doy <= 1) begin
        m_doy = yl; m_mon = 12; m_dom = 31; w = 1;
      end else begin
        m_doy--;
        m_dom--;
        if (m_dom == 0) begin
          m_mon--;
          m_dom = mlen(m_mon, lp);
        end
      end
    end
  endtask

  // One clock: model the edge just taken with the held inputs, then compare.
  task automatic cyc(input string tag);
    bit a, w;
    @(negedge clk);
    w = 0;
    if (reset) begin
      m_doy = 1; m_mon = 1; m_dom = 1; m_cnt = 0; m_tick = 0;
    end else begin
      a = run ? m_tick : step;
      if (a) advance(dir, leap, w);
      m_tick = (m_cnt >= divs[speed] - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
    end
    m_wrap = w;
    chk({tag, ".doy"},   32'(doy_bcd), to_bcd(m_doy));
    chk({tag, ".month"}, 32'(month),   32'(m_mon));
    chk({tag, ".dom"},   32'(dom_bcd), to_bcd(m_dom));
    chk({tag, ".tick"},  32'(tick),    32'(m_tick));
    chk({tag, ".wrap"},  32'(wrap),    32'(m_wrap));
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; dir = 1'b0;
    cyc("rst");
    cyc("rst");
    reset = 1'b0;
  endtask

  task automatic do_step(input string tag);
    step = 1'b1;
    cyc(tag);
    step = 1'b0;
    cyc(tag);
  endtask

  initial begin
    int nt;
    int yes;

    do_reset();
    chk("reset.doy",   32'(doy_bcd), 32'h001);
    chk("reset.month", 32'(month),   32'd1);
    chk("reset.dom",   32'(dom_bcd), 32'h01);
    chk("reset.tick",  32'(tick),    32'd0);
    chk("reset.wrap",  32'(wrap),    32'd0);

    speed = 2'd0;
    nt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc("pre0");
      nt += int'(tick);
    end
    chk("pre0.ticks", 32'(nt), 32'd4);

    do_reset();
    for (int i = 0; i < 4; i++) cyc("pre_mid");
    speed = 2'd3;
    nt = 0;
    for (int i = 0; i < 2; i++) begin
      cyc("pre_sw");
      nt += int'(tick);
    end
    chk("pre_sw.tick_seen", 32'(nt > 0), 32'd1);
    for (int i = 0; i < 10; i++) cyc("pre3");
    speed = 2'd0;

    do_reset();
    yes = 0;
    for (int i = 0; i < 31; i++) begin
      do_step("step31");
      yes += int'(wrap);
    end
    chk("step31.doy",   32'(doy_bcd), 32'h032);
    chk("step31.month", 32'(month),   32'd2);
    chk("step31.dom",   32'(dom_bcd), 32'h01);
    chk("step31.nowrap", 32'(yes),    32'd0);

    do_reset();
    leap = 1'b1;
    for (int i = 0; i < 58; i++) do_step("to59");
    chk("feb28.doy", 32'(doy_bcd), 32'h059);
    step = 1'b1;
    cyc("leap1");
    step = 1'b0;
    chk("leap1.doy",   32'(doy_bcd), 32'h060);
    chk("leap1.month", 32'(month),   32'd2);
    chk("leap1.dom",   32'(dom_bcd), 32'h29);
    cyc("leap1");
    leap = 1'b0;
    do_step("feb29_clr");
    chk("feb29clr.doy",   32'(doy_bcd), 32'h061);
    chk("feb29clr.month", 32'(month),   32'd3);
    chk("feb29clr.dom",   32'(dom_bcd), 32'h01);

    do_reset();
    leap = 1'b0;
    for (int i = 0; i < 58; i++) do_step("to59b");
    do_step("leap0");
    chk("leap0.doy",   32'(doy_bcd), 32'h060);
    chk("leap0.month", 32'(month),   32'd3);
    chk("leap0.dom",   32'(dom_bcd), 32'h01);

    do_reset();
    for (int i = 0; i < 364; i++) do_step("to365");
    chk("dec31.doy",   32'(doy_bcd), 32'h365);
    chk("dec31.month", 32'(month),   32'd12);
    chk("dec31.dom",   32'(dom_bcd), 32'h31);
    step = 1'b1;
    cyc("wrapup");
    step = 1'b0;
    chk("wrapup.doy",  32'(doy_bcd), 32'h001);
    chk("wrapup.wrap", 32'(wrap),    32'd1);
    cyc("wrapup2");
    chk("wrapup.wrap_once", 32'(wrap), 32'd0);

    do_reset();
    leap = 1'b1;
    dir = 1'b1;
    step = 1'b1;
    cyc("wrapdn");
    step = 1'b0;
    chk("wrapdn.doy",   32'(doy_bcd), 32'h366);
    chk("wrapdn.month", 32'(month),   32'd12);
    chk("wrapdn.dom",   32'(dom_bcd), 32'h31);
    chk("wrapdn.wrap",  32'(wrap),    32'd1);
    cyc("wrapdn2");
    leap = 1'b0;
    dir = 1'b0;
    do_step("d366_clr");
    chk("d366clr.doy", 32'(doy_bcd), 32'h001);

    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      leap = 1'($urandom);
      for (int i = 0; i < 200; i++) begin
        dir = 1'($urandom);
        do_step("rnd_step");
      end
    end

    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      leap = 1'($urandom);
      run = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(15) == 0) speed = 2'($urandom);
        if ($urandom_range(7) == 0) dir = 1'($urandom);
        if ($urandom_range(63) == 0) run = ~run;
        step = 1'($urandom);
        cyc("rnd_run");
      end
      run = 1'b0;
      step = 1'b0;
    end

    do_reset();
    run = 1'b1;
    speed = 2'd3;
    for (int i = 0; i < 7; i++) cyc("rst_mid");
    reset = 1'b1;
    step = 1'b1;
    cyc("rst_mid_r");
    reset = 1'b0;
    step = 1'b0;
    chk("rstmid.doy", 32'(doy_bcd), 32'h001);
    chk("rstmid.tick", 32'(tick),   32'd0);
    run = 1'b0;
    cyc("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
